fetch_seq: RTL and testbench

//  Next-PC sequencer and fetch controller in front of the instruction memory. Owns the PC

---
 rtl/fetch_seq_pkg.sv | 40 ++++
 rtl/fetch_seq_pc_redirect_sel.sv | 65 ++++++
 rtl/fetch_seq.sv | 115 +++++++++++
 tb/tb_fetch_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer: state and redirect-cause
// encodings, default reset/exception addresses and the target check helper.
package fetch_seq_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
    localparam int unsigned DEF_IM_AW    = 10;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_PEND = 2'd3
    } state_t;

    // Numeric order is the redirect priority order.
    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_BR   = 2'd1,
        CAUSE_ERET = 2'd2,
        CAUSE_EXC  = 2'd3
    } cause_t;

    typedef struct packed {
        cause_t      cause;
        logic [31:0] target;
    } redir_t;

    // Misaligned, or outside the IM window starting at base (32-bit wrap).
    function automatic logic target_bad(input logic [31:0] target,
                                        input logic [31:0] base,
                                        input int unsigned aw);
        logic [31:0] off;
        logic [32:0] span;
        off  = target - base;
        span = 33'd4 << aw;
        return (target[1:0] != 2'b00) || ({1'b0, off} >= span);
    endfunction

endpackage

// File: rtl/fetch_seq_pc_redirect_sel.sv
// Combinational next-PC priority select with target alignment/range trap.
module pc_redirect_sel
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC,
    parameter int unsigned IM_AW    = DEF_IM_AW
) (
    input  logic [31:0] add4,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc_in,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        pend_valid,
    input  logic [31:0] pend_target,
    output logic [1:0]  req_cause_c,
    output logic [31:0] req_target_c,
    output logic [31:0] next_pc_c,
    output logic        err_c
);

    logic [31:0] chosen;
    logic        use_chk;

    // Highest-priority redirect presented this cycle (ignores the latched one).
    always_comb begin
        req_cause_c  = 2'(CAUSE_NONE);
        req_target_c = 32'd0;
        if (exc_req) begin
            req_cause_c  = 2'(CAUSE_EXC);
            req_target_c = EXC_VEC;
        end else if (eret_req) begin
            req_cause_c  = 2'(CAUSE_ERET);
            req_target_c = epc_in;
        end else if (br_valid) begin
            req_cause_c  = 2'(CAUSE_BR);
            req_target_c = br_target;
        end
    end

    // New request beats latched one; sequential fall-through is never trapped.
    always_comb begin
        chosen    = add4;
        use_chk   = 1'b0;
        next_pc_c = add4;
        err_c     = 1'b0;
        if (exc_req) begin
            chosen = EXC_VEC;
        end else if (req_cause_c != 2'(CAUSE_NONE)) begin
            chosen  = req_target_c;
            use_chk = 1'b1;
        end else if (pend_valid) begin
            chosen  = pend_target;
            use_chk = 1'b1;
        end
        if (use_chk && target_bad(chosen, RESET_PC, IM_AW)) begin
            next_pc_c = EXC_VEC;
            err_c     = 1'b1;
        end else begin
            next_pc_c = chosen;
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// Next-PC sequencer / fetch controller: PC register, stall hold and redirect latch.
// Optional FETCH_CNT_EN adds the fetch_cnt cycle counter port.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC,
    parameter int unsigned IM_AW    = DEF_IM_AW
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [31:0]      br_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [31:0]      epc_in,
    output logic [31:0]      PC,
    output logic [31:0]      ADD4,
    output logic [IM_AW-1:0] im_addr,
    output logic             fetch_valid,
    output logic             redir_pending,
`ifdef FETCH_CNT_EN
    output logic [31:0]      fetch_cnt,
`endif
    output logic             addr_err
);

    state_t      state, state_nxt;
    redir_t      pend, pend_nxt;
    logic [31:0] pc_nxt;
    logic        err_nxt;

    logic [1:0]  req_cause;
    logic [31:0] req_target;
    logic [31:0] sel_pc;
    logic        sel_err;

    assign ADD4        = PC + 32'd4;
    assign im_addr     = IM_AW'((PC - RESET_PC) >> 2);
    assign fetch_valid = (state != ST_BOOT) && !stall;

    pc_redirect_sel #(
        .RESET_PC (RESET_PC),
        .EXC_VEC  (EXC_VEC),
        .IM_AW    (IM_AW)
    ) u_sel (
        .add4         (ADD4),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc_in       (epc_in),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .pend_valid   (state == ST_PEND),
        .pend_target  (pend.target),
        .req_cause_c  (req_cause),
        .req_target_c (req_target),
        .next_pc_c    (sel_pc),
        .err_c        (sel_err)
    );

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state         <= ST_BOOT;
            PC            <= RESET_PC;
            pend          <= '0;
            redir_pending <= 1'b0;
            addr_err      <= 1'b0;
        end else begin
            state         <= state_nxt;
            PC            <= pc_nxt;
            pend          <= pend_nxt;
            redir_pending <= (state_nxt == ST_PEND);
            addr_err      <= err_nxt;
        end
    end

    // Exceptions act even when stalled; other redirects latch until release.
    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        pend_nxt  = pend;
        err_nxt   = 1'b0;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            default: begin
                if (exc_req || !stall) begin
                    pc_nxt    = sel_pc;
                    err_nxt   = sel_err;
                    pend_nxt  = '0;
                    state_nxt = ST_RUN;
                end else if (req_cause != 2'(CAUSE_NONE)) begin
                    if (state != ST_PEND || cause_t'(req_cause) >= pend.cause) begin
                        pend_nxt.cause  = cause_t'(req_cause);
                        pend_nxt.target = req_target;
                    end
                    state_nxt = ST_PEND;
                end else if (state == ST_RUN) begin
                    state_nxt = ST_HOLD;
                end
            end
        endcase
    end

`ifdef FETCH_CNT_EN
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            fetch_cnt <= 32'd0;
        end else if (fetch_valid) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios plus a randomized run
// compared against a rule-level PC model.
module tb_fetch_seq;

    logic        Clk;
    logic        Clr;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc_in;
    logic [31:0] PC;
    logic [31:0] ADD4;
    logic [9:0]  im_addr;
    logic        fetch_valid;
    logic        redir_pending;
    logic        addr_err;
    logic [31:0] fetch_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    bit          m_boot;
    bit          m_pend;
    int          m_pend_prio;
    logic [31:0] m_pend_tgt;
    logic [31:0] m_pc;
    bit          m_err;
    logic [31:0] m_cnt;

    fetch_seq dut (
        .Clk           (Clk),
        .Clr           (Clr),
        .stall         (stall),
        .br_valid      (br_valid),
        .br_target     (br_target),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .epc_in        (epc_in),
        .PC            (PC),
        .ADD4          (ADD4),
        .im_addr       (im_addr),
        .fetch_valid   (fetch_valid),
        .redir_pending (redir_pending),
`ifdef FETCH_CNT_EN
        .fetch_cnt     (fetch_cnt),
`endif
        .addr_err      (addr_err)
    );

`ifndef FETCH_CNT_EN
    assign fetch_cnt = m_cnt;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_boot = 1; m_pend = 0; m_pend_prio = 0; m_pend_tgt = 32'd0;
        m_pc = 32'h3000; m_err = 0; m_cnt = 32'd0;
    endtask

    // Rules: exc > eret > br > pending > pc+4; non-sequential targets trapped.
    task automatic model_step();
        logic [31:0] tgt;
        bit chk;
        int prio;
        if (m_boot) begin m_boot = 0; m_err = 0; return; end
        m_err = 0;
        if (!stall) m_cnt = m_cnt + 32'd1;
        if (exc_req) begin
            m_pc = 32'h4180; m_pend = 0;
        end else if (!stall) begin
            chk = 1;
            if (eret_req)      tgt = epc_in;
            else if (br_valid) tgt = br_target;
            else if (m_pend)   tgt = m_pend_tgt;
            else begin tgt = m_pc + 32'd4; chk = 0; end
            if (chk && (tgt[1:0] != 2'b00 || (tgt - 32'h3000) >= 32'd4096)) begin
                m_pc = 32'h4180; m_err = 1;
            end else begin
                m_pc = tgt;
            end
            m_pend = 0;
        end else if (eret_req || br_valid) begin
            prio = eret_req ? 2 : 1;
            tgt  = eret_req ? epc_in : br_target;
            if (!m_pend || prio >= m_pend_prio) begin
                m_pend_tgt = tgt; m_pend_prio = prio;
            end
            m_pend = 1;
        end
    endtask

    task automatic set_in(input bit s, input bit b, input logic [31:0] bt,
                          input bit e, input bit r, input logic [31:0] ep);
        stall = s; br_valid = b; br_target = bt; exc_req = e; eret_req = r; epc_in = ep;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        Clr = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        n_cmp++; if (PC !== 32'h3000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC, 32'h3000); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", fetch_valid); end
        n_cmp++; if (redir_pending !== 1'b0) begin n_fail++; $display("FAIL reset_rp: got %b want 0", redir_pending); end
        n_cmp++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", addr_err); end
        @(posedge Clk); #1;
        Clr = 1'b0;
        @(negedge Clk);
        n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL boot_fv: got %b want 0", fetch_valid); end
        n_cmp++; if (PC !== 32'h3000) begin n_fail++; $display("FAIL boot_pc: got %h want %h", PC, 32'h3000); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h3000 + 32'(4 * i);
            n_cmp++; if (PC !== exp_pc) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, PC, exp_pc); end
            n_cmp++; if (im_addr !== 10'(i)) begin n_fail++; $display("FAIL seq_im[%0d]: got %h want %h", i, im_addr, i); end
            n_cmp++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fv[%0d]: got %b want 1", i, fetch_valid); end
            n_cmp++; if (ADD4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL seq_add4[%0d]: got %h want %h", i, ADD4, exp_pc + 32'd4); end
            if (i < 2) tick();
        end
    endtask

    task automatic test_stall_branch();
        tick();  // 3008 -> 300C
        set_in(1, 1, 32'h3040, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        #1;
        n_cmp++; if (PC !== 32'h300C) begin n_fail++; $display("FAIL stall_pc: got %h want %h", PC, 32'h300C); end
        n_cmp++; if (redir_pending !== 1'b1) begin n_fail++; $display("FAIL stall_rp: got %b want 1", redir_pending); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL stall_fv: got %b want 0", fetch_valid); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (PC !== 32'h3040) begin n_fail++; $display("FAIL release_pc: got %h want %h", PC, 32'h3040); end
        n_cmp++; if (im_addr !== 10'h010) begin n_fail++; $display("FAIL release_im: got %h want %h", im_addr, 10'h010); end
        n_cmp++; if (redir_pending !== 1'b0) begin n_fail++; $display("FAIL release_rp: got %b want 0", redir_pending); end
    endtask

    task automatic test_pend_replace();
        set_in(1, 1, 32'h3040, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 1, 32'h3100);
        tick();
        set_in(1, 1, 32'h3200, 0, 0, 0);  // lower priority than latched eret: dropped
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (PC !== 32'h3100) begin n_fail++; $display("FAIL replace_pc: got %h want %h", PC, 32'h3100); end
    endtask

    task automatic test_exc_stall();
        set_in(1, 1, 32'h3200, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 1, 0, 0);
        tick();
        n_cmp++; if (PC !== 32'h4180) begin n_fail++; $display("FAIL exc_pc: got %h want %h", PC, 32'h4180); end
        n_cmp++; if (redir_pending !== 1'b0) begin n_fail++; $display("FAIL exc_rp: got %b want 0", redir_pending); end
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (PC !== 32'h4184) begin n_fail++; $display("FAIL exc_after_pc: got %h want %h", PC, 32'h4184); end
    endtask

    task automatic test_addr_err();
        logic [31:0] bad [2];
        bad[0] = 32'h3042;
        bad[1] = 32'h5000;
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1, bad[i], 0, 0, 0);
            tick();
            n_cmp++; if (PC !== 32'h4180) begin n_fail++; $display("FAIL err_pc[%0d]: got %h want %h", i, PC, 32'h4180); end
            n_cmp++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse[%0d]: got %b want 1", i, addr_err); end
            set_in(0, 0, 0, 0, 0, 0);
            tick();
            n_cmp++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL err_clear[%0d]: got %b want 0", i, addr_err); end
        end
    endtask

    task automatic test_async_clr();
        set_in(1, 1, 32'h3040, 0, 0, 0);
        tick();
        @(negedge Clk); #2;
        Clr = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (PC !== 32'h3000) begin n_fail++; $display("FAIL clr_pc: got %h want %h", PC, 32'h3000); end
        n_cmp++; if (redir_pending !== 1'b0) begin n_fail++; $display("FAIL clr_rp: got %b want 0", redir_pending); end
`ifdef FETCH_CNT_EN
        n_cmp++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", fetch_cnt); end
`endif
        @(posedge Clk); #1;
        Clr = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        tick();  // BOOT -> RUN
        for (int i = 1; i <= 3; i++) begin
            tick();
`ifdef FETCH_CNT_EN
            n_cmp++; if (fetch_cnt !== 32'(i)) begin n_fail++; $display("FAIL cnt[%0d]: got %0d want %0d", i, fetch_cnt, i); end
`endif
            n_cmp++; if (PC !== 32'h3000 + 32'(4 * i)) begin n_fail++; $display("FAIL clr_seq_pc[%0d]: got %h want %h", i, PC, 32'h3000 + 32'(4 * i)); end
        end
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        int unsigned r;
        r = $urandom_range(0, 9);
        t = 32'h3000 + (32'($urandom_range(0, 1023)) << 2);
        if (r == 6)      t = t + 32'($urandom_range(1, 3));
        else if (r == 7) t = 32'h4000 + (32'($urandom_range(0, 4095)) << 2);
        else if (r == 8) t = 32'h0000_1000;
        else if (r == 9) t = 32'hFFFF_FFFC;
        return t;
    endfunction

    task automatic test_random();
        logic [31:0] d;
        for (int i = 0; i < 500; i++) begin
            set_in($urandom_range(0, 9) < 4, $urandom_range(0, 4) == 0, pick_target(),
                   $urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0, pick_target());
            @(negedge Clk);
            d = m_pc - 32'h3000;
            n_cmp++; if (PC !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, PC, m_pc); end
            n_cmp++; if (im_addr !== d[11:2]) begin n_fail++; $display("FAIL rnd_im[%0d]: got %h want %h", i, im_addr, d[11:2]); end
            n_cmp++; if (ADD4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_add4[%0d]: got %h want %h", i, ADD4, m_pc + 32'd4); end
            n_cmp++; if (fetch_valid !== (!m_boot && !stall)) begin n_fail++; $display("FAIL rnd_fv[%0d]: got %b want %b", i, fetch_valid, !m_boot && !stall); end
            n_cmp++; if (redir_pending !== m_pend) begin n_fail++; $display("FAIL rnd_rp[%0d]: got %b want %b", i, redir_pending, m_pend); end
            n_cmp++; if (addr_err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, addr_err, m_err); end
`ifdef FETCH_CNT_EN
            n_cmp++; if (fetch_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, fetch_cnt, m_cnt); end
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_branch();
        test_pend_replace();
        test_exc_stall();
        test_addr_err();
        test_async_clr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
